serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/fpu_addsub_pkg.sv | 13 +
 rtl/addsub_chunk.sv | 30 +++
 rtl/serial_addsub.sv | 128 ++++++++++++
 tb/tb_serial_addsub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_addsub_pkg.sv
// Shared FSM state and operation encodings for the serial add/subtract unit.
package fpu_addsub_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational ripple adder slice; also exposes the carry into its MSB for overflow.
module addsub_chunk
    import fpu_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[WIDTH];
    assign cmsb = c[WIDTH-1];

endmodule

// File: rtl/serial_addsub.sv
// Chunk-serial add/subtract, CHUNK bits per cycle, valid/ready on both sides.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub
    import fpu_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned K    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (K > 1) ? $clog2(K) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub: WIDTH must be at least 2");
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  sum_chunk;
    logic              cout_chunk;
    logic              cmsb_chunk;
    logic              last_chunk;
    logic              is_sub;

    assign is_sub     = (op == OP_SUB);
    assign a_chunk    = a_q[idx_q * CHUNK +: CHUNK];
    assign b_chunk    = b_q[idx_q * CHUNK +: CHUNK];
    assign last_chunk = (idx_q == IDXW'(K - 1));

    addsub_chunk #(
        .WIDTH (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (cout_chunk),
        .cmsb (cmsb_chunk)
    );

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // Subtract as a + ~b + 1: invert b here, inject the +1 as carry-in.
                        a_q      <= a;
                        b_q      <= b ^ {WIDTH{is_sub}};
                        carry_q  <= is_sub;
                        idx_q    <= '0;
                        cout     <= 1'b0;
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    result[idx_q * CHUNK +: CHUNK] <= sum_chunk;
                    carry_q <= cout_chunk;
                    if (last_chunk) begin
                        cout    <= cout_chunk;
                        ovf     <= cmsb_chunk ^ cout_chunk;
                        idx_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    // First DONE cycle finalises the result; out_valid rises after it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
`ifdef SERIAL_ADDSUB_SAT_EN
                        // On overflow the wrapped sign is inverted from the true sign.
                        if (ovf) begin
                            result <= result[WIDTH-1] ? SMAX : SMIN;
                        end
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8, CHUNK=2).
module tb_serial_addsub;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 2;
    localparam int unsigned LAT   = WIDTH / CHUNK + 1;
`ifdef SERIAL_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    serial_addsub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready before accept", 32'(in_ready), 32'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~x;
        b = ~y;
        op = ~o;
        chk("in_ready low after accept", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] r, output logic co, output logic ov,
                         output int lat);
        start_op(o, x, y);
        wait_valid(lat);
        r  = result;
        co = cout;
        ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready after handshake", 32'(in_ready), 32'd1);
        chk("out_valid after handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        logic             co;
        logic             ov;
        int               lat;

        //          op    a      b      result                    cout  ovf
        vecs[0]  = '{1'b1, 8'h05, 8'h03, 8'h02,                    1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h03, 8'h05, 8'hFE,                    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80,      1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F,      1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'hFF, 8'h01, 8'h00,                    1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h80, 8'h80, SAT ? 8'h80 : 8'h00,      1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'h00, 8'h00, 8'h00,                    1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h10, 8'h20, 8'h30,                    1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h5A, 8'hA5, 8'hFF,                    1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h7F, 8'hFF, SAT ? 8'h7F : 8'h80,      1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h3C, 8'h0F, 8'h4B,                    1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, co, ov, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].res));
            chk($sformatf("vec%0d cout", i), 32'(co), 32'(vecs[i].co));
            chk($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ov));
        end

        // Stall in DONE with junk on the input side; nothing may be accepted.
        start_op(1'b1, 8'h05, 8'h03);
        wait_valid(lat);
        chk("hold latency", 32'(lat), 32'(LAT));
        for (int c = 0; c < 3; c++) begin
            in_valid = ~in_valid;
            a = 8'(c * 37 + 11);
            b = 8'(c * 5 + 1);
            @(posedge clk); #1;
            chk($sformatf("hold%0d result", c), 32'(result), 32'h02);
            chk($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold release in_ready", 32'(in_ready), 32'd1);
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("no phantom accept out_valid", 32'(out_valid), 32'd0);
        chk("no phantom accept in_ready", 32'(in_ready), 32'd1);

        // Abort during the second RUN cycle.
        start_op(1'b0, 8'h01, 8'h02);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        chk("abort ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort no output", 32'(out_valid), 32'd0);
        do_op(1'b0, 8'h10, 8'h20, r, co, ov, lat);
        chk("post-abort latency", 32'(lat), 32'(LAT));
        chk("post-abort result", 32'(r), 32'h30);
        chk("post-abort cout", 32'(co), 32'd0);
        chk("post-abort ovf", 32'(ov), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
